// File: rtl/dma_pkg.sv
// Shared sizing defaults and scheduler FSM encoding for the DMA channel scheduler.
package dma_pkg;
  localparam int DMA_NUM_CH = 4;
  localparam int DMA_SIZE_W = 10;
  localparam int DMA_ADDR_W = 32;
  localparam int DMA_CH_W   = $clog2(DMA_NUM_CH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sched_state_t;
endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational channel picker: round-robin after 'last', or lowest index when
// DMA_SCHED_FIXED_PRIO_EN is defined (then 'last' is ignored).
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int CH_W   = DMA_CH_W
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

`ifdef DMA_SCHED_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = CH_W'(i);
      end
    end
  end
`else
  logic [CH_W-1:0] cand;

  // Walk offsets from farthest to nearest so the channel right after 'last' wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = CH_W'((int'(last) + off) % NUM_CH);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/dma_ch_sched.sv
// Arms a channel on ch_en rise, grants one channel at a time and holds its latched descriptor on
// xfer_req until xfer_ack; ch_done is registered one cycle after DONE. DMA_SCHED_FIXED_PRIO_EN: fixed priority.
module dma_ch_sched
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int SIZE_W = DMA_SIZE_W,
  parameter int ADDR_W = DMA_ADDR_W
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH-1:0]          ch_target,
  input  logic [NUM_CH*SIZE_W-1:0]   ch_size,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_sour,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_dest,
  output logic                       xfer_req,
  input  logic                       xfer_ack,
  input  logic                       xfer_done,
  output logic [$clog2(NUM_CH)-1:0]  xfer_ch,
  output logic                       xfer_dir,
  output logic [SIZE_W-1:0]          xfer_len,
  output logic [ADDR_W-1:0]          xfer_src,
  output logic [ADDR_W-1:0]          xfer_dst,
  output logic [NUM_CH-1:0]          ch_done,
  output logic                       busy
);
  localparam int CH_W = $clog2(NUM_CH);

  sched_state_t      state, state_nxt;
  logic [NUM_CH-1:0] en_q, pending, rise, gnt, ch_done_nxt;
  logic [CH_W-1:0]   rr_last, gnt_idx;
  logic              take;
  logic              sel_dir;
  logic [SIZE_W-1:0] sel_size;
  logic [ADDR_W-1:0] sel_src, sel_dst;

  assign rise = ch_en & ~en_q;
  assign take = (state == IDLE) && (|pending);

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req     (pending),
    .last    (rr_last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_dir  = 1'b0;
    sel_size = '0;
    sel_src  = '0;
    sel_dst  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_dir  = ch_target[i];
        sel_size = ch_size[i*SIZE_W +: SIZE_W];
        sel_src  = ch_sour[i*ADDR_W +: ADDR_W];
        sel_dst  = ch_dest[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Zero-length descriptors skip the engine entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = (sel_size == '0) ? DONE : REQ;
      REQ:     if (xfer_ack) state_nxt = WAIT;
      WAIT:    if (xfer_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    xfer_req    = (state == REQ);
    busy        = (state != IDLE);
    ch_done_nxt = '0;
    if (state == DONE) ch_done_nxt[xfer_ch] = 1'b1;
  end

  // A rise in the same cycle as a clear keeps the channel armed.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q     <= '0;
      pending  <= '0;
      rr_last  <= CH_W'(NUM_CH - 1);
      xfer_ch  <= '0;
      xfer_dir <= 1'b0;
      xfer_len <= '0;
      xfer_src <= '0;
      xfer_dst <= '0;
      ch_done  <= '0;
    end else begin
      en_q    <= ch_en;
      pending <= (pending & ~(take ? gnt : '0) & ch_en) | rise;
      ch_done <= ch_done_nxt;
      if (take) begin
        xfer_ch  <= gnt_idx;
        xfer_dir <= sel_dir;
        xfer_len <= sel_size;
        xfer_src <= sel_src;
        xfer_dst <= sel_dst;
        rr_last  <= gnt_idx;
      end
    end
  end

endmodule
